// File: rtl/renorm_div_scheduler.sv
// Perspective renormalization sequencer: one vertex at a time, x/z then y/z through
// a single shared divider, followed by a viewport bounds check and a cull counter.
module renorm_div_scheduler #(
  parameter int IN_WIDTH  = 20,
  parameter int FRAC_BITS = 14,
  parameter int Q_WIDTH   = 2*IN_WIDTH+1,
  parameter int LIMIT     = 1 << FRAC_BITS,
  parameter int CNT_WIDTH = 16
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       valid_in,
  input  logic [3*IN_WIDTH-1:0]      ndc,
  output logic                       ready_out,
  output logic                       div_start,
  output logic signed [Q_WIDTH-1:0]  div_a,
  output logic signed [Q_WIDTH-1:0]  div_b,
  input  logic                       div_done,
  input  logic                       div_err,
  input  logic signed [Q_WIDTH-1:0]  div_q,
  output logic                       valid_out,
  input  logic                       ready_in,
  output logic signed [Q_WIDTH-1:0]  x_renorm,
  output logic signed [Q_WIDTH-1:0]  y_renorm,
  output logic signed [IN_WIDTH-1:0] z,
  output logic [CNT_WIDTH-1:0]       cull_count
);

  localparam logic signed [Q_WIDTH-1:0] POS_LIMIT = Q_WIDTH'(LIMIT);
  localparam logic signed [Q_WIDTH-1:0] NEG_LIMIT = -POS_LIMIT;

  typedef enum logic [2:0] {IDLE, DIV_X, DIV_Y, CHECK, OUT} state_t;

  state_t                      r_state, w_state_next;
  logic                        r_first;
  logic signed [IN_WIDTH-1:0]  r_comp [3];
  logic signed [IN_WIDTH-1:0]  w_ndc [3];
  logic signed [Q_WIDTH-1:0]   w_ext [3];
  logic signed [Q_WIDTH-1:0]   r_xq, r_yq;
  logic signed [Q_WIDTH-1:0]   r_x_renorm, r_y_renorm;
  logic signed [IN_WIDTH-1:0]  r_z_out;
  logic [CNT_WIDTH-1:0]        r_cull_count;
  logic                        w_latch, w_cull, w_store_x, w_store_y, w_load_out;
  logic                        w_z_le0, w_pass;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_comp
      assign w_ndc[gi] = ndc[gi*IN_WIDTH +: IN_WIDTH];
      assign w_ext[gi] = {{(Q_WIDTH-IN_WIDTH){r_comp[gi][IN_WIDTH-1]}}, r_comp[gi]};
    end
  endgenerate

  assign w_z_le0 = r_comp[2][IN_WIDTH-1] || (r_comp[2] == '0);
  assign w_pass  = (r_xq < POS_LIMIT) && (r_xq > NEG_LIMIT) &&
                   (r_yq < POS_LIMIT) && (r_yq > NEG_LIMIT);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_first <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_first <= (w_state_next != r_state);
    end
  end

  // A division state's first cycle issues the start; a z <= 0 vertex is culled
  // there instead, so the divider is never touched for it.
  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_cull       = 1'b0;
    w_store_x    = 1'b0;
    w_store_y    = 1'b0;
    w_load_out   = 1'b0;
    div_start    = 1'b0;
    div_a        = '0;
    div_b        = '0;
    case (r_state)
      IDLE: begin
        if (valid_in) begin
          w_latch      = 1'b1;
          w_state_next = DIV_X;
        end
      end
      DIV_X: begin
        div_a = w_ext[0];
        div_b = w_ext[2];
        if (r_first) begin
          if (w_z_le0) begin
            w_cull       = 1'b1;
            w_state_next = IDLE;
          end else begin
            div_start = 1'b1;
          end
        end else if (div_done) begin
          if (div_err) begin
            w_cull       = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_store_x    = 1'b1;
            w_state_next = DIV_Y;
          end
        end
      end
      DIV_Y: begin
        div_a = w_ext[1];
        div_b = w_ext[2];
        if (r_first) begin
          div_start = 1'b1;
        end else if (div_done) begin
          if (div_err) begin
            w_cull       = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_store_y    = 1'b1;
            w_state_next = CHECK;
          end
        end
      end
      CHECK: begin
        if (w_pass) begin
          w_load_out   = 1'b1;
          w_state_next = OUT;
        end else begin
          w_cull       = 1'b1;
          w_state_next = IDLE;
        end
      end
      OUT: begin
        if (ready_in) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < 3; i++) r_comp[i] <= '0;
      r_xq         <= '0;
      r_yq         <= '0;
      r_x_renorm   <= '0;
      r_y_renorm   <= '0;
      r_z_out      <= '0;
      r_cull_count <= '0;
    end else begin
      if (w_latch) begin
        for (int i = 0; i < 3; i++) r_comp[i] <= w_ndc[i];
      end
      if (w_store_x) r_xq <= div_q;
      if (w_store_y) r_yq <= div_q;
      if (w_load_out) begin
        r_x_renorm <= r_xq;
        r_y_renorm <= r_yq;
        r_z_out    <= r_comp[2];
      end
      if (w_cull && (r_cull_count != '1)) r_cull_count <= r_cull_count + 1'b1;
    end
  end

  assign ready_out  = (r_state == IDLE);
  assign valid_out  = (r_state == OUT);
  assign x_renorm   = r_x_renorm;
  assign y_renorm   = r_y_renorm;
  assign z          = r_z_out;
  assign cull_count = r_cull_count;

endmodule

// File: tb/tb_renorm_div_scheduler.sv
// Bench for renorm_div_scheduler: latency-configurable divider stub, vector table,
// hand-written corner sequences and randomized vertices against an arithmetic model.
module tb_renorm_div_scheduler;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic               valid_in;
  logic [59:0]        ndc;
  logic               ready_out, div_start, valid_out, ready_in;
  logic signed [40:0] div_a, div_b;
  logic               div_done = 1'b0;
  logic               div_err  = 1'b0;
  logic signed [40:0] div_q    = '0;
  logic signed [40:0] x_renorm, y_renorm;
  logic signed [19:0] z;
  logic [15:0]        cull_count;

  int total = 0;
  int bad   = 0;

  renorm_div_scheduler dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .ndc(ndc),
    .ready_out(ready_out), .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_err(div_err), .div_q(div_q),
    .valid_out(valid_out), .ready_in(ready_in),
    .x_renorm(x_renorm), .y_renorm(y_renorm), .z(z), .cull_count(cull_count)
  );

  always #5 clk_in = ~clk_in;

  // Divider stub: result strobe lat cycles after the start cycle; not reset by rst_in
  // so an in-flight division can deliver a late strobe.
  int     lat    = 5;
  int     starts = 0;
  int     err_at = -1;
  int     st_cnt = 0;
  logic   st_busy = 1'b0;
  longint st_q = 0;
  logic   st_err = 1'b0;

  always @(posedge clk_in) begin
    longint q_c;
    logic   e_c;
    div_done <= 1'b0;
    if (div_start) begin
      q_c = (div_b == 0) ? 64'sd0 : ((longint'(div_a) <<< 14) / longint'(div_b));
      e_c = (starts == err_at) || (div_b == 0);
      starts <= starts + 1;
      if (lat == 1) begin
        div_done <= 1'b1;
        div_q    <= q_c[40:0];
        div_err  <= e_c;
      end else begin
        st_busy <= 1'b1;
        st_cnt  <= lat - 1;
        st_q    <= q_c;
        st_err  <= e_c;
      end
    end else if (st_busy) begin
      if (st_cnt == 1) begin
        div_done <= 1'b1;
        div_q    <= st_q[40:0];
        div_err  <= st_err;
        st_busy  <= 1'b0;
      end
      st_cnt <= st_cnt - 1;
    end
  end

  task automatic chk(input string name, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Offers one vertex; returns at #1 after the accepting edge.
  task automatic send(input int xx, input int yy, input int zz);
    int n = 0;
    while (!ready_out && n < 200) begin
      @(posedge clk_in); #1; n++;
    end
    if (!ready_out) chk("send_ready_timeout", 0, 1);
    valid_in = 1'b1;
    ndc = {20'(zz), 20'(yy), 20'(xx)};
    @(posedge clk_in); #1;
    valid_in = 1'b0;
  endtask

  // Counts edges until valid_out rises or the FSM is back in IDLE.
  task automatic wait_end(output int k);
    k = 0;
    do begin
      @(posedge clk_in); #1; k++;
    end while (!valid_out && !ready_out && k < 100);
    if (k >= 100) chk("wait_end_timeout", k, 0);
  endtask

  typedef struct {
    int     x, y, zz;
    bit     pass;
    longint xq, yq;
    int     k;
  } vec_t;

  initial begin
    vec_t   tbl [8];
    int     k, cc0, s0, n, first_n, exp_cc;
    bit     got_v, armed, exp_pass;
    int     rx, ry, rz;
    longint mxq, myq;

    tbl[0] = '{x: 8192,   y: -4096,  zz: 16384, pass: 1, xq: 8192,   yq: -4096, k: 13};
    tbl[1] = '{x: 16384,  y: 0,      zz: 16384, pass: 0, xq: 0,      yq: 0,     k: 13};
    tbl[2] = '{x: 100,    y: 100,    zz: 0,     pass: 0, xq: 0,      yq: 0,     k: 1};
    tbl[3] = '{x: 5,      y: 5,      zz: -5,    pass: 0, xq: 0,      yq: 0,     k: 1};
    tbl[4] = '{x: 4096,   y: 4096,   zz: 8192,  pass: 1, xq: 8192,   yq: 8192,  k: 13};
    tbl[5] = '{x: -16383, y: 16383,  zz: 16384, pass: 1, xq: -16383, yq: 16383, k: 13};
    tbl[6] = '{x: 100,    y: -16384, zz: 16384, pass: 0, xq: 0,      yq: 0,     k: 13};
    tbl[7] = '{x: 3000,   y: 7000,   zz: 32768, pass: 1, xq: 1500,   yq: 3500,  k: 13};

    rst_in = 1'b1; valid_in = 1'b0; ready_in = 1'b1; ndc = '0;
    #1;
    chk("rst_ready", ready_out, 1);
    chk("rst_valid", valid_out, 0);
    chk("rst_start", div_start, 0);
    chk("rst_cull", cull_count, 0);
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;

    // Vector table at divider latency 5.
    lat = 5;
    for (int i = 0; i < 8; i++) begin
      cc0 = cull_count;
      s0  = starts;
      send(tbl[i].x, tbl[i].y, tbl[i].zz);
      wait_end(k);
      chk($sformatf("vec%0d_edges", i), k, tbl[i].k);
      chk($sformatf("vec%0d_valid", i), valid_out, tbl[i].pass);
      if (tbl[i].pass) begin
        chk($sformatf("vec%0d_x", i), x_renorm, tbl[i].xq);
        chk($sformatf("vec%0d_y", i), y_renorm, tbl[i].yq);
        chk($sformatf("vec%0d_z", i), z, tbl[i].zz);
        chk($sformatf("vec%0d_cull", i), cull_count, cc0);
        @(posedge clk_in); #1;
        chk($sformatf("vec%0d_release", i), ready_out, 1);
      end else begin
        chk($sformatf("vec%0d_cull", i), cull_count, cc0 + 1);
        if (tbl[i].zz <= 0) chk($sformatf("vec%0d_nostart", i), starts - s0, 0);
      end
    end

    // Divider error on the x division.
    cc0 = cull_count;
    s0  = starts;
    err_at = starts;
    send(8192, 0, 16384);
    wait_end(k);
    chk("err_edges", k, 6);
    chk("err_valid", valid_out, 0);
    repeat (3) @(posedge clk_in);
    #1;
    chk("err_starts", starts - s0, 1);
    chk("err_cull", cull_count, cc0 + 1);

    // Downstream stall for 10 cycles.
    ready_in = 1'b0;
    send(4096, -8192, 16384);
    wait_end(k);
    chk("bp_edges", k, 13);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_in); #1;
      chk("bp_valid", valid_out, 1);
      chk("bp_ready", ready_out, 0);
      chk("bp_x", x_renorm, 4096);
      chk("bp_y", y_renorm, -8192);
    end
    ready_in = 1'b1;
    @(posedge clk_in); #1;
    chk("bp_drop", valid_out, 0);
    chk("bp_idle", ready_out, 1);

    // Asynchronous reset in the middle of the y division.
    send(8192, 8192, 16384);
    repeat (8) @(posedge clk_in);
    #1;
    chk("mid_divy_a", div_a, 8192);
    chk("mid_divy_b", div_b, 16384);
    #2 rst_in = 1'b1;
    #1;
    chk("arst_ready", ready_out, 1);
    chk("arst_valid", valid_out, 0);
    chk("arst_start", div_start, 0);
    chk("arst_a", div_a, 0);
    chk("arst_b", div_b, 0);
    chk("arst_x", x_renorm, 0);
    chk("arst_y", y_renorm, 0);
    chk("arst_z", z, 0);
    chk("arst_cull", cull_count, 0);
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    s0 = starts;
    got_v = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk_in); #1;
      if (valid_out || !ready_out) got_v = 1'b1;
    end
    chk("late_done_ignored", got_v, 0);
    chk("late_no_start", starts - s0, 0);

    // Randomized vertices against the arithmetic model.
    exp_cc = cull_count;
    for (int v = 0; v < 40; v++) begin
      rx = int'($urandom_range(0, 65535)) - 32768;
      ry = int'($urandom_range(0, 65535)) - 32768;
      if ($urandom_range(0, 5) == 0) rz = -int'($urandom_range(0, 50));
      else                           rz = int'($urandom_range(1, 60000));
      lat   = int'($urandom_range(1, 4));
      armed = (rz > 0) && ($urandom_range(0, 7) == 0);
      if (armed) err_at = starts;
      if (rz > 0) begin
        mxq = (longint'(rx) * 16384) / longint'(rz);
        myq = (longint'(ry) * 16384) / longint'(rz);
      end else begin
        mxq = 0;
        myq = 0;
      end
      exp_pass = (rz > 0) && !armed && (mxq < 0 ? -mxq : mxq) < 16384 &&
                 (myq < 0 ? -myq : myq) < 16384;
      if (!exp_pass && exp_cc != 65535) exp_cc++;

      send(rx, ry, rz);
      got_v = 1'b0;
      first_n = 0;
      n = 0;
      while (n < 200) begin
        ready_in = 1'($urandom_range(0, 1));
        @(posedge clk_in); #1; n++;
        if (valid_out && !got_v) begin
          got_v = 1'b1;
          first_n = n;
          if (exp_pass) begin
            chk("rnd_x", x_renorm, mxq);
            chk("rnd_y", y_renorm, myq);
            chk("rnd_z", z, rz);
          end
        end
        if (ready_out) break;
      end
      chk("rnd_timeout", (n < 200) ? 1 : 0, 1);
      chk($sformatf("rnd%0d_pass", v), got_v, exp_pass);
      if (got_v) chk("rnd_latency", first_n, 2*lat + 3);
      chk("rnd_cull", cull_count, exp_cc);
    end
    ready_in = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
